// File: rtl/ahb3lite_pkg.sv
// ahb3lite_pkg: shared types and constants for the AHB3-Lite slave memory path.
package ahb3lite_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_BURST, ARB_DONE} arb_state;
    localparam int ARB_WORD_BYTES = 4;
endpackage

// File: rtl/ahb3lite_burst_ctr.sv
// ahb3lite_burst_ctr: beat address register, beat counter and last-beat flag for port B bursts.
// Ports: clk_i/rst_i clock and sync active-high reset; load_i latches addr_i/len_i;
// advance_i steps to the next word unless hold_i pauses it; addr_o is the current beat
// address; last_o is high when the current beat is the final one.
module ahb3lite_burst_ctr
    import ahb3lite_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic        hold_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  len_i,
    output logic [31:0] addr_o,
    output logic        last_o
);
    logic [31:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            addr_d = addr_i;
            cnt_d  = len_i;
        end else if (advance_i && !hold_i) begin
            // Address wraps naturally modulo 2^32.
            addr_d = addr_q + 32'(ARB_WORD_BYTES);
            cnt_d  = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (cnt_q == 4'd0);
endmodule

// File: rtl/ahb3lite_mem_arbiter.sv
// ahb3lite_mem_arbiter: shares one memory port between AHB slave port A (absolute priority) and burst port B.
// Ports: HCLK/HRESET clock and sync active-high reset; a_* port A pass-through;
// b_cmd_* burst command handshake; b_wdata/b_beat_ack write beat data and issue strobe;
// b_rdata/b_rvalid registered read data; b_done end-of-burst pulse; b_starved preemption
// flag; mem_* memory port. Optional macro ARB_STATS_EN adds the b_conflicts counter port.
module ahb3lite_mem_arbiter
    import ahb3lite_pkg::*;
#(
    parameter int STARVE_LIMIT = 16
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] a_addr,
    input  logic        a_read,
    input  logic        a_write,
    input  logic [31:0] a_wdata,
    output logic [31:0] a_rdata,
    input  logic        b_cmd_valid,
    output logic        b_cmd_ready,
    input  logic [31:0] b_cmd_addr,
    input  logic        b_cmd_write,
    input  logic [3:0]  b_cmd_len,
    input  logic [31:0] b_wdata,
    output logic        b_beat_ack,
    output logic [31:0] b_rdata,
    output logic        b_rvalid,
    output logic        b_done,
    output logic        b_starved,
`ifdef ARB_STATS_EN
    output logic [31:0] b_conflicts,
`endif
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [15:0] LIMIT = 16'(STARVE_LIMIT);

    arb_state    state_q, state_d;
    logic        wr_q, wr_d;
    logic [15:0] starve_q, starve_d;
    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic [31:0] beat_addr;
    logic        last;
    logic        a_act, in_burst, beat, accept;

    assign a_act    = a_read | a_write;
    assign in_burst = (state_q == ARB_BURST);
    assign beat     = in_burst && !a_act;
    assign accept   = (state_q == ARB_IDLE) && b_cmd_valid;

    ahb3lite_burst_ctr u_ctr (
        .clk_i    (HCLK),
        .rst_i    (HRESET),
        .load_i   (accept),
        .advance_i(in_burst),
        .hold_i   (a_act),
        .addr_i   (b_cmd_addr),
        .len_i    (b_cmd_len),
        .addr_o   (beat_addr),
        .last_o   (last)
    );

    // Both A strobes high is treated as a write.
    assign mem_addr    = a_act ? a_addr : (beat ? beat_addr : '0);
    assign mem_write   = a_act ? a_write : (beat && wr_q);
    assign mem_read    = a_act ? (a_read && !a_write) : (beat && !wr_q);
    assign mem_wdata   = a_act ? a_wdata : (beat ? b_wdata : '0);
    assign a_rdata     = mem_rdata;
    assign b_beat_ack  = beat;
    assign b_cmd_ready = (state_q == ARB_IDLE);
    assign b_done      = (state_q == ARB_DONE);
    assign b_starved   = (starve_q == LIMIT);
    assign b_rdata     = rdata_q;
    assign b_rvalid    = rvalid_q;

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        starve_d = starve_q;
        case (state_q)
            ARB_IDLE: begin
                starve_d = '0;
                if (b_cmd_valid) begin
                    state_d = ARB_BURST;
                    wr_d    = b_cmd_write;
                end
            end
            ARB_BURST: begin
                if (a_act)
                    starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 16'd1;
                else begin
                    starve_d = '0;
                    if (last) state_d = ARB_DONE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q  <= ARB_IDLE;
            wr_q     <= 1'b0;
            starve_q <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            starve_q <= starve_d;
            rvalid_q <= beat && !wr_q;
            if (beat && !wr_q) rdata_q <= mem_rdata;
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] conf_q;
    always_ff @(posedge HCLK) begin
        if (HRESET)
            conf_q <= '0;
        else if (in_burst && a_act && conf_q != 32'hFFFF_FFFF)
            conf_q <= conf_q + 32'd1;
    end
    assign b_conflicts = conf_q;
`endif
endmodule
